// File: rtl/gobou_mac_ctrl_if.sv
// gobou mac sequencer bus: layer-controller request/ack plus
// mac strobes and memory addresses driven by the sequencer.
interface gobou_mac_ctrl_if #(
  parameter int NIN_W   = 12,
  parameter int NOUT_W  = 10,
  parameter int WADDR_W = 22
);
  logic               req;
  logic [NIN_W-1:0]   n_in;
  logic [NOUT_W-1:0]  n_out;
  logic               busy;
  logic               ack;
  logic [NIN_W-1:0]   in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic               accum_we;
  logic               out_en;
  logic               mac_reset;
  logic               out_we;
  logic [NOUT_W-1:0]  out_addr;

  modport master (
    output req, n_in, n_out,
    input  busy, ack, in_addr, w_addr,
    input  accum_we, out_en, mac_reset,
    input  out_we, out_addr
  );

  modport slave (
    input  req, n_in, n_out,
    output busy, ack, in_addr, w_addr,
    output accum_we, out_en, mac_reset,
    output out_we, out_addr
  );
endinterface

// File: rtl/gobou_mac_ctrl.sv
// gobou mac sequencer: walks input/weight addresses per neuron
// and drives accum_we / out_en / mac_reset / out_we strobes.
module gobou_mac_ctrl #(
  parameter int NIN_W   = 12,
  parameter int NOUT_W  = 10,
  parameter int WADDR_W = 22,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            xrst,
  gobou_mac_ctrl_if.slave bus
);
  localparam int DW = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, FEED, DRAIN, OUT, CLEAR, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NIN_W-1:0]   nin_q, nin_d;
  logic [NIN_W-1:0]   i_q, i_d;
  logic [NOUT_W-1:0]  nout_q, nout_d;
  logic [NOUT_W-1:0]  o_q, o_d;
  logic [WADDR_W-1:0] w_q, w_d;
  logic [DW-1:0]      dc_q, dc_d;
  logic [MAC_LAT-1:0] dl_q, dl_d;

  logic feed_valid;
  logic last_term;
  logic last_neuron;
  logic drain_end;
  logic zero_len;

  assign feed_valid  = (state_q == FEED);
  assign last_term   = (i_q == nin_q - NIN_W'(1));
  assign last_neuron = (o_q == nout_q - NOUT_W'(1));
  assign drain_end   = (dc_q == DW'(MAC_LAT - 1));
  assign zero_len    = (bus.n_in == '0) || (bus.n_out == '0);

  // state and datapath registers, cleared asynchronously on xrst
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q <= IDLE;
      nin_q   <= '0;
      nout_q  <= '0;
      i_q     <= '0;
      o_q     <= '0;
      w_q     <= '0;
      dc_q    <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      nin_q   <= nin_d;
      nout_q  <= nout_d;
      i_q     <= i_d;
      o_q     <= o_d;
      w_q     <= w_d;
      dc_q    <= dc_d;
      dl_q    <= dl_d;
    end
  end

  // next-state sequencing across feed/drain/out/clear per neuron
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.req) state_d = zero_len ? DONE : FEED;
      FEED:  if (last_term) state_d = DRAIN;
      DRAIN: if (drain_end) state_d = OUT;
      OUT:   state_d = CLEAR;
      CLEAR: state_d = last_neuron ? DONE : FEED;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // term/neuron/weight counters; weight address only ever increments
  always_comb begin
    nin_d  = nin_q;
    nout_d = nout_q;
    i_d    = i_q;
    o_d    = o_q;
    w_d    = w_q;
    dc_d   = '0;
    dl_d   = (dl_q << 1) | MAC_LAT'(feed_valid);
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          nin_d  = bus.n_in;
          nout_d = bus.n_out;
          i_d    = '0;
          o_d    = '0;
          w_d    = '0;
        end
      end
      FEED: begin
        if (!last_term) begin
          i_d = i_q + NIN_W'(1);
          w_d = w_q + WADDR_W'(1);
        end
      end
      DRAIN: dc_d = dc_q + DW'(1);
      CLEAR: begin
        if (!last_neuron) begin
          o_d = o_q + NOUT_W'(1);
          i_d = '0;
          w_d = w_q + WADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // strobes decoded from registered state; all zero during reset
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.ack       = 1'b0;
    bus.out_en    = 1'b0;
    bus.mac_reset = 1'b0;
    bus.out_we    = 1'b0;
    bus.out_addr  = '0;
    bus.in_addr   = i_q;
    bus.w_addr    = w_q;
    bus.accum_we  = dl_q[MAC_LAT-1];
    unique case (1'b1)
      (state_q == OUT): bus.out_en = 1'b1;
      (state_q == CLEAR): begin
        bus.mac_reset = 1'b1;
        bus.out_we    = 1'b1;
        bus.out_addr  = o_q;
      end
      (state_q == DONE): bus.ack = 1'b1;
      default: ;
    endcase
  end
endmodule
